vip_rgb2ycbcr_cfg: RTL and testbench
====================================

Name: vip_rgb2ycbcr_cfg

Overview:
Parametrised successor to the fixed RGB888→YCbCr444 converter in the VIP pipeline. Converts a vsync/href-framed RGB pixel stream to YCbCr of configurable bit width. Supports BT.601 or BT.709 full-range coefficients and an optional 4:2:2 chroma-averaged output mode. Sits directly after sensor/testbench pixel input and ahead of frame-difference and filter stages.

Parameters:
DATA_WIDTH, 8, bits per colour component in and out (6..12)
EN_422, 1, 1 = 4:2:2 averaging hardware present; 0 = cfg_422 ignored, treated as 0

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset; asynchronous assert, active-low
cfg_709  input  1  coefficient set: 0 = BT.601, 1 = BT.709
cfg_422  input  1  1 = 4:2:2 chroma averaging
per_img_vsync  input  1  frame valid, high for whole frame
per_img_href  input  1  pixel valid within line
per_img_red  input  DATA_WIDTH  R
per_img_green  input  DATA_WIDTH  G
per_img_blue  input  DATA_WIDTH  B
post_img_vsync  output  1  per_img_vsync delayed by LAT
post_img_href  output  1  per_img_href delayed by LAT
post_img_Y  output  DATA_WIDTH  luma
post_img_Cb  output  DATA_WIDTH  Cb (pair-averaged in 422 mode)
post_img_Cr  output  DATA_WIDTH  Cr (pair-averaged in 422 mode)
post_img_C422  output  DATA_WIDTH  interleaved chroma: Cb on even pixel, Cr on odd; equals Cb in 444 mode

Behaviour:
- Reset: all outputs and all pipeline registers are 0, including vsync/href delay lines; pair state is cleared.
- Latency LAT = 5 clocks in every mode. post_img_vsync and post_img_href are exact 5-cycle delays of the inputs.
- Config: cfg_709 and cfg_422 are sampled into shadow registers only on a per_img_vsync rising edge. The sampled values hold for the whole frame, so mid-frame changes have no effect until the next frame.
- Coefficients are signed fixed point scaled ×256:
  - BT.601: Y = 77,150,29; Cb = −43,−85,128; Cr = 128,−107,−21.
  - BT.709: Y = 54,183,19; Cb = −29,−99,128; Cr = 128,−116,−12.
- Arithmetic:
  - Each channel: sum of products + offset + 128, then arithmetic shift right by 8.
  - Offset is 0 for Y and 2^(DATA_WIDTH−1)·256 for Cb/Cr.
  - Result clamps to [0, 2^DATA_WIDTH−1].
  - Internal accumulator is signed, DATA_WIDTH+11 bits.
- Pipeline stages:
  - S1: register inputs.
  - S2: products.
  - S3: sums + offset/round.
  - S4: shift/clamp.
  - S5: 4:2:2 pairing/output.
  - Y passes S5 unchanged.
- Pixel parity: a parity bit toggles per valid pixel at S4 and resets to even (0) whenever href is low.
- 4:2:2 mode:
  - Each even pixel is held in S5.
  - Even pixel n and odd pixel n+1 both output Cb = (Cb_n+Cb_n+1+1)>>1, and likewise for Cr.
  - C422 carries averaged Cb on the even pixel and averaged Cr on the odd pixel.
- Odd-length line: the unpaired last even pixel uses its own Cb/Cr, with no averaging.
- Output data while post_img_href = 0: unspecified, but held stable.
- rst_n asserted mid-frame: immediate flush, all outputs 0. After release, processing resumes on the next href, with config taken from the next vsync rising edge; until then the shadow defaults are 601/444.

Test Plan:
- 601/444, DATA_WIDTH=8, pixel (255,255,255) → Y=255 Cb=128 Cr=128; pixel (0,0,0) → Y=0 Cb=128 Cr=128; output href exactly 5 clocks after input href.
- 601 pixel (255,0,0) → Y=77 Cb=85 Cr=255 (clamped from 256); 709 same pixel → Y=54 Cb=99 Cr=255.
- 601/422 line alternating red,black (4 pixels) → Cb=107,107,107,107; Cr=192,192,192,192; C422=107,192,107,192; Y=77,0,77,0.
- 422, 3-pixel line red,black,red → third pixel Cb=85 Cr=255 C422=85 (unpaired); next line restarts at even parity.
- Toggle cfg_709 mid-frame → no change until next vsync rising edge, then new coefficients; red pixel Y changes 77→54.
- Assert rst_n low mid-line, release → all outputs 0 immediately; full 640×480 frame afterwards matches golden image_YCbCr.txt; row count = 480, 640 pixels/row.

Source files
------------

// File: rtl/vip_rgb2ycbcr_cfg.sv
// RGB to YCbCr converter with run-time BT.601/BT.709 selection and optional 4:2:2 chroma pair averaging.
// Five-stage pipeline: register, multiply, sum/round, shift/clamp, pair/output.
module vip_rgb2ycbcr_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter bit EN_422     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_709,
  input  logic                  cfg_422,
  input  logic                  per_img_vsync,
  input  logic                  per_img_href,
  input  logic [DATA_WIDTH-1:0] per_img_red,
  input  logic [DATA_WIDTH-1:0] per_img_green,
  input  logic [DATA_WIDTH-1:0] per_img_blue,
  output logic                  post_img_vsync,
  output logic                  post_img_href,
  output logic [DATA_WIDTH-1:0] post_img_Y,
  output logic [DATA_WIDTH-1:0] post_img_Cb,
  output logic [DATA_WIDTH-1:0] post_img_Cr,
  output logic [DATA_WIDTH-1:0] post_img_C422
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 11;
  localparam logic signed [AW-1:0] Y_RND  = AW'(128);
  localparam logic signed [AW-1:0] CH_OFF = (AW'(1) << (W + 7)) + AW'(128);
  localparam logic signed [AW-1:0] MAXV   = (AW'(1) << W) - AW'(1);

  // Stream framing: vsync is high for the whole frame, href marks each valid
  // pixel; there is no back-pressure, both are delayed unchanged by 5 clocks.
  logic [4:0] vs_d, hr_d;

  logic vsync_q, armed, sh_709, sh_422, mode_422;
  logic [W-1:0] r1, g1, b1;
  logic signed [9:0] ky_r, ky_g, ky_b, kb_r, kb_g, kb_b, kr_r, kr_g, kr_b;
  logic signed [AW-1:0] p_yr, p_yg, p_yb, p_br, p_bg, p_bb, p_rr, p_rg, p_rb;
  logic signed [AW-1:0] s_y, s_cb, s_cr;
  logic [W-1:0] y4, cb4, cr4, cb3c, cr3c, hold_cb, hold_cr;
  logic         par4;
  logic [W-1:0] y5, cb5, cr5, c5;

  function automatic logic signed [AW-1:0] mul(input logic [W-1:0] px, input logic signed [9:0] k);
    logic signed [AW-1:0] a, b;
    a = signed'(AW'(px));
    b = AW'(k);
    return a * b;
  endfunction

  function automatic logic [W-1:0] clamp(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] t;
    t = s >>> 8;
    if (t < 0) return '0;
    else if (t > MAXV) return MAXV[W-1:0];
    else return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] avg(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    return s[W:1];
  endfunction

  always_comb begin
    if (sh_709) begin
      ky_r = 10'sd54;   ky_g = 10'sd183;  ky_b = 10'sd19;
      kb_r = -10'sd29;  kb_g = -10'sd99;  kb_b = 10'sd128;
      kr_r = 10'sd128;  kr_g = -10'sd116; kr_b = -10'sd12;
    end else begin
      ky_r = 10'sd77;   ky_g = 10'sd150;  ky_b = 10'sd29;
      kb_r = -10'sd43;  kb_g = -10'sd85;  kb_b = 10'sd128;
      kr_r = 10'sd128;  kr_g = -10'sd107; kr_b = -10'sd21;
    end
  end

  assign mode_422 = EN_422 && sh_422;
  // Chroma of the pixel one stage behind S4, i.e. the partner of an even pixel.
  assign cb3c = clamp(s_cb);
  assign cr3c = clamp(s_cr);

  // Config shadows; armed blocks a false rising edge when reset releases mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      armed   <= 1'b0;
      sh_709  <= 1'b0;
      sh_422  <= 1'b0;
    end else begin
      vsync_q <= per_img_vsync;
      if (!per_img_vsync) armed <= 1'b1;
      if (per_img_vsync && !vsync_q && armed) begin
        sh_709 <= cfg_709;
        sh_422 <= cfg_422;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= '0;   hr_d <= '0;
      r1 <= '0;     g1 <= '0;     b1 <= '0;
      p_yr <= '0;   p_yg <= '0;   p_yb <= '0;
      p_br <= '0;   p_bg <= '0;   p_bb <= '0;
      p_rr <= '0;   p_rg <= '0;   p_rb <= '0;
      s_y <= '0;    s_cb <= '0;   s_cr <= '0;
      y4 <= '0;     cb4 <= '0;    cr4 <= '0;    par4 <= 1'b0;
      hold_cb <= '0; hold_cr <= '0;
      y5 <= '0;     cb5 <= '0;    cr5 <= '0;    c5 <= '0;
    end else begin
      vs_d <= {vs_d[3:0], per_img_vsync};
      hr_d <= {hr_d[3:0], per_img_href};
      r1 <= per_img_red;  g1 <= per_img_green;  b1 <= per_img_blue;
      p_yr <= mul(r1, ky_r);  p_yg <= mul(g1, ky_g);  p_yb <= mul(b1, ky_b);
      p_br <= mul(r1, kb_r);  p_bg <= mul(g1, kb_g);  p_bb <= mul(b1, kb_b);
      p_rr <= mul(r1, kr_r);  p_rg <= mul(g1, kr_g);  p_rb <= mul(b1, kr_b);
      s_y  <= p_yr + p_yg + p_yb + Y_RND;
      s_cb <= p_br + p_bg + p_bb + CH_OFF;
      s_cr <= p_rr + p_rg + p_rb + CH_OFF;
      y4   <= clamp(s_y);
      cb4  <= cb3c;
      cr4  <= cr3c;
      par4 <= hr_d[2] && hr_d[3] && !par4;
      if (hr_d[3]) begin
        y5 <= y4;
        if (!mode_422) begin
          cb5 <= cb4;
          cr5 <= cr4;
          c5  <= cb4;
        end else if (!par4) begin
          hold_cb <= cb4;
          hold_cr <= cr4;
          if (hr_d[2]) begin
            cb5 <= avg(cb4, cb3c);
            cr5 <= avg(cr4, cr3c);
            c5  <= avg(cb4, cb3c);
          end else begin
            cb5 <= cb4;
            cr5 <= cr4;
            c5  <= cb4;
          end
        end else begin
          cb5 <= avg(hold_cb, cb4);
          cr5 <= avg(hold_cr, cr4);
          c5  <= avg(hold_cr, cr4);
        end
      end
    end
  end

  assign post_img_vsync = vs_d[4];
  assign post_img_href  = hr_d[4];
  assign post_img_Y     = y5;
  assign post_img_Cb    = cb5;
  assign post_img_Cr    = cr5;
  assign post_img_C422  = c5;

endmodule

// File: tb/tb_vip_rgb2ycbcr_cfg.sv
// Directed bench for vip_rgb2ycbcr_cfg: expected pixels queued by the drivers, checked by a monitor.
module tb_vip_rgb2ycbcr_cfg;

  localparam int W = 8;

  logic         clk, rst_n, cfg_709, cfg_422;
  logic         per_img_vsync, per_img_href;
  logic [W-1:0] per_img_red, per_img_green, per_img_blue;
  logic         post_img_vsync, post_img_href;
  logic [W-1:0] post_img_Y, post_img_Cb, post_img_Cr, post_img_C422;

  int total = 0;
  int bad   = 0;
  logic [4*W-1:0] exp_q[$];
  logic [4:0] hr_hist, vs_hist;

  vip_rgb2ycbcr_cfg #(.DATA_WIDTH(W), .EN_422(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_709(cfg_709), .cfg_422(cfg_422),
    .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
    .per_img_red(per_img_red), .per_img_green(per_img_green), .per_img_blue(per_img_blue),
    .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
    .post_img_Y(post_img_Y), .post_img_Cb(post_img_Cb), .post_img_Cr(post_img_Cr),
    .post_img_C422(post_img_C422)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference framing delay: both syncs must reappear exactly 5 clocks later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_hist <= '0;
      vs_hist <= '0;
    end else begin
      hr_hist <= {hr_hist[3:0], per_img_href};
      vs_hist <= {vs_hist[3:0], per_img_vsync};
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("href_delay", int'(post_img_href), int'(hr_hist[4]));
      check("vsync_delay", int'(post_img_vsync), int'(vs_hist[4]));
      if (post_img_href) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          logic [4*W-1:0] e;
          e = exp_q.pop_front();
          check("Y",    int'(post_img_Y),    int'(e[4*W-1:3*W]));
          check("Cb",   int'(post_img_Cb),   int'(e[3*W-1:2*W]));
          check("Cr",   int'(post_img_Cr),   int'(e[2*W-1:W]));
          check("C422", int'(post_img_C422), int'(e[W-1:0]));
        end
      end
    end
  end

  // Drivers: each is entered and left 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [W-1:0] r, g, b, y, cb, cr, c4);
    per_img_href  = 1'b1;
    per_img_red   = r;
    per_img_green = g;
    per_img_blue  = b;
    exp_q.push_back({y, cb, cr, c4});
    tick();
  endtask

  task automatic idle(input int n);
    per_img_href = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame_start(input logic c709, input logic c422);
    per_img_vsync = 1'b0;
    cfg_709 = c709;
    cfg_422 = c422;
    idle(3);
    per_img_vsync = 1'b1;
    idle(2);
  endtask

  task automatic frame_end();
    idle(8);
    per_img_vsync = 1'b0;
    idle(2);
  endtask

  task automatic red_px(input logic [W-1:0] y, cb, cr, c4);
    px(8'd255, 8'd0, 8'd0, y, cb, cr, c4);
  endtask

  task automatic black_px(input logic [W-1:0] cb, cr, c4);
    px(8'd0, 8'd0, 8'd0, 8'd0, cb, cr, c4);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_709 = 1'b0;
    cfg_422 = 1'b0;
    per_img_vsync = 1'b0;
    per_img_href  = 1'b0;
    per_img_red = '0;  per_img_green = '0;  per_img_blue = '0;
    #1;
    check("rst_Y", int'(post_img_Y), 0);
    check("rst_href", int'(post_img_href), 0);
    check("rst_C422", int'(post_img_C422), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 601 / 444: primaries and extremes, then a mid-frame 709 request that must not apply.
    frame_start(1'b0, 1'b0);
    px(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 8'd128);
    px(8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 8'd128);
    red_px(8'd77, 8'd85, 8'd255, 8'd85);
    px(8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21, 8'd43);
    px(8'd0, 8'd0, 8'd255, 8'd29, 8'd255, 8'd107, 8'd255);
    idle(3);
    cfg_709 = 1'b1;
    idle(2);
    red_px(8'd77, 8'd85, 8'd255, 8'd85);
    frame_end();

    // 709 / 444 takes effect on the next vsync rising edge.
    frame_start(1'b1, 1'b0);
    red_px(8'd54, 8'd99, 8'd255, 8'd99);
    px(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 8'd128);
    frame_end();

    // 601 / 422: even line, odd line with unpaired tail, then parity restart.
    frame_start(1'b0, 1'b1);
    red_px(8'd77, 8'd107, 8'd192, 8'd107);
    black_px(8'd107, 8'd192, 8'd192);
    red_px(8'd77, 8'd107, 8'd192, 8'd107);
    black_px(8'd107, 8'd192, 8'd192);
    idle(3);
    red_px(8'd77, 8'd107, 8'd192, 8'd107);
    black_px(8'd107, 8'd192, 8'd192);
    red_px(8'd77, 8'd85, 8'd255, 8'd85);
    idle(3);
    red_px(8'd77, 8'd107, 8'd192, 8'd107);
    black_px(8'd107, 8'd192, 8'd192);
    frame_end();

    // 709 frame interrupted by reset mid-line; shadows fall back to 601/444.
    frame_start(1'b1, 1'b0);
    red_px(8'd54, 8'd99, 8'd255, 8'd99);
    red_px(8'd54, 8'd99, 8'd255, 8'd99);
    rst_n = 1'b0;
    per_img_href = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_Y", int'(post_img_Y), 0);
    check("midrst_Cb", int'(post_img_Cb), 0);
    check("midrst_Cr", int'(post_img_Cr), 0);
    check("midrst_C422", int'(post_img_C422), 0);
    check("midrst_href", int'(post_img_href), 0);
    check("midrst_vsync", int'(post_img_vsync), 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    red_px(8'd77, 8'd85, 8'd255, 8'd85);
    black_px(8'd128, 8'd128, 8'd128);
    frame_end();

    // A clean vsync rising edge restores 709.
    frame_start(1'b1, 1'b0);
    red_px(8'd54, 8'd99, 8'd255, 8'd99);
    frame_end();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
